// File: rtl/chess_pkg.sv
// ---------------------------------------------------------------------------
// chess_pkg -- shared square encoding, board types and the start position.
//
// Square byte = {color[7:6], piece[5:0]} with a one-hot piece field.
// EMPTY reuses the WHITE color code with an all-ones piece field, so any
// color comparison must rule out EMPTY first.
//
// Exports: square_t, sq_idx_t, board_t, color/piece constants, EMPTY,
//          state_t (board_writer FSM), START_BOARD, EMPTY_BOARD.
// ---------------------------------------------------------------------------
package chess_pkg;

  typedef logic [7:0]       square_t;
  typedef logic [5:0]       sq_idx_t;
  typedef logic [63:0][7:0] board_t;

  localparam logic [1:0] WHITE = 2'b01;
  localparam logic [1:0] BLACK = 2'b10;

  localparam logic [5:0] KING   = 6'b000001;
  localparam logic [5:0] QUEEN  = 6'b000010;
  localparam logic [5:0] ROOK   = 6'b000100;
  localparam logic [5:0] KNIGHT = 6'b001000;
  localparam logic [5:0] BISHOP = 6'b010000;
  localparam logic [5:0] PAWN   = 6'b100000;

  localparam square_t EMPTY = 8'b01_111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Piece on the back rank for a given column (R,N,B,Q,K,B,N,R).
  function automatic square_t back_rank(input logic [1:0] color,
                                        input logic [2:0] col);
    logic [5:0] piece;
    case (col)
      3'd0, 3'd7: piece = ROOK;
      3'd1, 3'd6: piece = KNIGHT;
      3'd2, 3'd5: piece = BISHOP;
      3'd3:       piece = QUEEN;
      default:    piece = KING;
    endcase
    return {color, piece};
  endfunction

  function automatic board_t make_start_board();
    board_t b;
    for (int i = 0; i < 64; i++) b[i] = EMPTY;
    for (int c = 0; c < 8; c++) begin
      b[c]      = back_rank(WHITE, 3'(c));
      b[8 + c]  = {WHITE, PAWN};
      b[48 + c] = {BLACK, PAWN};
      b[56 + c] = back_rank(BLACK, 3'(c));
    end
    return b;
  endfunction

  localparam board_t START_BOARD = make_start_board();
  localparam board_t EMPTY_BOARD = {64{EMPTY}};

endpackage

// File: rtl/move_check.sv
// ---------------------------------------------------------------------------
// move_check -- combinational legality test for a single move.
//
// Ports:
//   from_i, to_i   : source / destination square indices
//   src_sq_i       : current byte at the source square
//   dst_sq_i       : current byte at the destination square
//   legal_o        : 1 when the move may be committed
//
// A move is rejected when from==to, when the source is EMPTY, or when the
// destination holds a piece of the source's color. An EMPTY destination is
// never a same-color conflict even though EMPTY carries the WHITE code.
// ---------------------------------------------------------------------------
module move_check
  import chess_pkg::*;
(
  input  sq_idx_t from_i,
  input  sq_idx_t to_i,
  input  square_t src_sq_i,
  input  square_t dst_sq_i,
  output logic    legal_o
);

  logic same_sq;
  logic src_empty;
  logic own_piece;

  always_comb begin
    same_sq   = (from_i == to_i);
    src_empty = (src_sq_i == EMPTY);
    own_piece = (dst_sq_i != EMPTY) && (dst_sq_i[7:6] == src_sq_i[7:6]);
    legal_o   = !(same_sq || src_empty || own_piece);
  end

endmodule

// File: rtl/board_writer.sv
// ---------------------------------------------------------------------------
// board_writer -- registered 8x8 chess board with a move-commit FSM.
//
// Ports:
//   clk            : clock, rising edge
//   nrst           : asynchronous active-low reset
//   move_valid_i   : move request present
//   move_ready_o   : high in IDLE (and out of reset) -- move can be taken
//   move_from_i    : source square index (row*8+col)
//   move_to_i      : destination square index
//   init_i         : synchronous reload of the reset board, highest priority
//   grid_o         : board, grid_o[row][col], straight from registers
//   move_done_o    : one-cycle pulse, move committed
//   move_err_o     : one-cycle pulse, move rejected
//
// Parameter INIT_ON_RESET: 1 -> reset/init load the start position,
//                          0 -> reset/init load an all-EMPTY board.
// Optional macro PROMOTION_EN: a pawn landing on its last row is stored
// as a queen of the same color.
//
// Timing: accept at edge N (IDLE->CHECK), legality registered at N+1
// (CHECK->WRITE), board written at N+2 (WRITE->DONE), pulse visible for
// the cycle after N+2, back to IDLE at N+3.
// ---------------------------------------------------------------------------
module board_writer
  import chess_pkg::*;
#(
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 move_valid_i,
  output logic                 move_ready_o,
  input  logic [5:0]           move_from_i,
  input  logic [5:0]           move_to_i,
  input  logic                 init_i,
  output logic [7:0][7:0][7:0] grid_o,
  output logic                 move_done_o,
  output logic                 move_err_o
);

  localparam board_t RESET_BOARD = INIT_ON_RESET ? START_BOARD : EMPTY_BOARD;

  state_t  state_q;
  board_t  grid_q;
  sq_idx_t from_q;
  sq_idx_t to_q;
  logic    legal_q;
  logic    done_q;
  logic    err_q;

  square_t src_sq;
  square_t dst_sq;
  logic    legal_d;
  square_t wr_byte_d;

  assign src_sq = grid_q[from_q];
  assign dst_sq = grid_q[to_q];

  move_check u_move_check (
    .from_i   (from_q),
    .to_i     (to_q),
    .src_sq_i (src_sq),
    .dst_sq_i (dst_sq),
    .legal_o  (legal_d)
  );

`ifdef PROMOTION_EN
  // Row is the upper three bits of the index: white promotes on row 7,
  // black on row 0.
  always_comb begin
    wr_byte_d = src_sq;
    if (src_sq[5:0] == PAWN) begin
      if (((src_sq[7:6] == WHITE) && (to_q[5:3] == 3'd7)) ||
          ((src_sq[7:6] == BLACK) && (to_q[5:3] == 3'd0))) begin
        wr_byte_d = {src_sq[7:6], QUEEN};
      end
    end
  end
`else
  assign wr_byte_d = src_sq;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      grid_q  <= RESET_BOARD;
      from_q  <= '0;
      to_q    <= '0;
      legal_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      // init_i wins over everything, including an accept on this edge.
      if (init_i) begin
        grid_q  <= RESET_BOARD;
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (move_valid_i) begin
              from_q  <= move_from_i;
              to_q    <= move_to_i;
              state_q <= CHECK;
            end
          end
          CHECK: begin
            legal_q <= legal_d;
            state_q <= WRITE;
          end
          WRITE: begin
            if (legal_q) begin
              // Destination written first in source order, source cleared
              // last; from!=to is guaranteed for a legal move.
              grid_q[to_q]   <= wr_byte_d;
              grid_q[from_q] <= EMPTY;
              done_q         <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            state_q <= DONE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  // Qualified by nrst so ready stays low for the whole reset interval and
  // rises as soon as reset is released.
  assign move_ready_o = nrst && (state_q == IDLE);
  assign grid_o       = grid_q;
  assign move_done_o  = done_q;
  assign move_err_o   = err_q;

endmodule

// File: tb/tb_board_writer.sv
module tb_board_writer;

  logic                 clk;
  logic                 nrst;
  logic                 move_valid_i;
  logic                 move_ready_o;
  logic [5:0]           move_from_i;
  logic [5:0]           move_to_i;
  logic                 init_i;
  logic [7:0][7:0][7:0] grid_o;
  logic                 move_done_o;
  logic                 move_err_o;

  board_writer #(.INIT_ON_RESET(1'b1)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .move_valid_i (move_valid_i),
    .move_ready_o (move_ready_o),
    .move_from_i  (move_from_i),
    .move_to_i    (move_to_i),
    .init_i       (init_i),
    .grid_o       (grid_o),
    .move_done_o  (move_done_o),
    .move_err_o   (move_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [7:0] E  = 8'h7F;
  localparam logic [7:0] WK = 8'h41, WQ = 8'h42, WR = 8'h44, WN = 8'h48, WB = 8'h50, WP = 8'h60;
  localparam logic [7:0] BK = 8'h81, BQ = 8'h82, BR = 8'h84, BN = 8'h88, BB = 8'h90, BP = 8'hA0;
`ifdef PROMOTION_EN
  localparam logic [7:0] PROMO = WQ;
`else
  localparam logic [7:0] PROMO = WP;
`endif

  typedef struct {
    logic [5:0] from;
    logic [5:0] to;
    bit         exp_done;
    logic [7:0] exp_from_b;
    logic [7:0] exp_to_b;
  } vec_t;

  vec_t vecs[9];
  logic [63:0][7:0] start_m;
  logic [63:0][7:0] board_m;
  int total;
  int bad;

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] sq(input logic [5:0] idx);
    return grid_o[idx[5:3]][idx[2:0]];
  endfunction

  task automatic wait_ready(input string name);
    int w = 0;
    while (move_ready_o !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({name, "_ready_wait"}, 512'(move_ready_o), 512'(1));
  endtask

  task automatic do_move(input int idx);
    int nd = 0, ne = 0;
    logic rdy1 = 1'b1, rdy3 = 1'b1, rdy4 = 1'b0;
    logic [7:0] fb = 8'h00, tb = 8'h00;
    string nm;
    nm = $sformatf("vec%0d", idx);
    wait_ready(nm);
    move_valid_i = 1'b1;
    move_from_i  = vecs[idx].from;
    move_to_i    = vecs[idx].to;
    @(posedge clk);
    #1;
    move_valid_i = 1'b0;
    move_from_i  = ~vecs[idx].from;
    move_to_i    = ~vecs[idx].to;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      nd += int'(move_done_o);
      ne += int'(move_err_o);
      if (k == 1) rdy1 = move_ready_o;
      if (k == 3) begin
        rdy3 = move_ready_o;
        fb = sq(vecs[idx].from);
        tb = sq(vecs[idx].to);
      end
      if (k == 4) rdy4 = move_ready_o;
    end
    if (vecs[idx].exp_done) begin
      board_m[vecs[idx].to]   = vecs[idx].exp_to_b;
      board_m[vecs[idx].from] = vecs[idx].exp_from_b;
    end
    chk({nm, "_done_cnt"}, 512'(nd), 512'(vecs[idx].exp_done ? 1 : 0));
    chk({nm, "_err_cnt"},  512'(ne), 512'(vecs[idx].exp_done ? 0 : 1));
    chk({nm, "_rdy_n1"},   512'(rdy1), 512'(0));
    chk({nm, "_rdy_n3"},   512'(rdy3), 512'(0));
    chk({nm, "_rdy_n4"},   512'(rdy4), 512'(1));
    chk({nm, "_from_b"},   512'(fb), 512'(vecs[idx].exp_from_b));
    chk({nm, "_to_b"},     512'(tb), 512'(vecs[idx].exp_to_b));
    chk({nm, "_grid"},     512'(grid_o), 512'(board_m));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int nd, ne;
    total = 0;
    bad   = 0;

    for (int i = 0; i < 64; i++) start_m[i] = E;
    start_m[0] = WR; start_m[1] = WN; start_m[2] = WB; start_m[3] = WQ;
    start_m[4] = WK; start_m[5] = WB; start_m[6] = WN; start_m[7] = WR;
    start_m[56] = BR; start_m[57] = BN; start_m[58] = BB; start_m[59] = BQ;
    start_m[60] = BK; start_m[61] = BB; start_m[62] = BN; start_m[63] = BR;
    for (int i = 0; i < 8; i++) begin
      start_m[8 + i]  = WP;
      start_m[48 + i] = BP;
    end
    board_m = start_m;

    //         from to  done from_byte to_byte
    vecs[0] = '{6'd12, 6'd28, 1'b1, E,  WP};    // pawn push
    vecs[1] = '{6'd0,  6'd8,  1'b0, WR, WP};    // onto own pawn
    vecs[2] = '{6'd20, 6'd36, 1'b0, E,  E};     // empty source
    vecs[3] = '{6'd5,  6'd5,  1'b0, WB, WB};    // from == to
    vecs[4] = '{6'd57, 6'd42, 1'b1, E,  BN};    // black knight out
    vecs[5] = '{6'd42, 6'd28, 1'b1, E,  BN};    // knight takes pawn
    vecs[6] = '{6'd11, 6'd51, 1'b1, E,  WP};    // setup: white pawn to 51
    vecs[7] = '{6'd51, 6'd59, 1'b1, E,  PROMO}; // capture on back row
    vecs[8] = '{6'd48, 6'd56, 1'b0, BP, BR};    // black onto own rook

    // Reset, then idle
    nrst = 1'b0; move_valid_i = 1'b0; move_from_i = '0; move_to_i = '0; init_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready_low", 512'(move_ready_o), 512'(0));
    chk("rst_done_low",  512'(move_done_o),  512'(0));
    chk("rst_err_low",   512'(move_err_o),   512'(0));
    nrst = 1'b1;
    #1;
    chk("rel_ready",   512'(move_ready_o), 512'(1));
    chk("rel_sq04",    512'(grid_o[0][4]), 512'(8'b01_000001));
    chk("rel_sq73",    512'(grid_o[7][3]), 512'(8'b10_000010));
    chk("rel_sq33",    512'(grid_o[3][3]), 512'(E));
    chk("rel_grid",    512'(grid_o), 512'(start_m));
    @(negedge clk);

    // Table of moves
    for (int i = 0; i < 9; i++) do_move(i);

    // init_i during CHECK aborts the move and reloads the board
    wait_ready("init_abort");
    move_valid_i = 1'b1; move_from_i = 6'd9; move_to_i = 6'd25;
    @(posedge clk);
    #1;
    move_valid_i = 1'b0;
    @(negedge clk);
    init_i = 1'b1;
    @(posedge clk);
    #1;
    init_i = 1'b0;
    nd = 0; ne = 0;
    @(negedge clk);
    chk("init_ready_next", 512'(move_ready_o), 512'(1));
    chk("init_grid", 512'(grid_o), 512'(start_m));
    for (int k = 0; k < 4; k++) begin
      nd += int'(move_done_o); ne += int'(move_err_o);
      @(negedge clk);
    end
    chk("init_no_pulse", 512'(nd + ne), 512'(0));
    board_m = start_m;

    // init_i on the accepting edge cancels the move
    move_valid_i = 1'b1; move_from_i = 6'd12; move_to_i = 6'd28; init_i = 1'b1;
    @(posedge clk);
    #1;
    move_valid_i = 1'b0; init_i = 1'b0;
    nd = 0; ne = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      nd += int'(move_done_o); ne += int'(move_err_o);
    end
    chk("initacc_no_pulse", 512'(nd + ne), 512'(0));
    chk("initacc_ready",    512'(move_ready_o), 512'(1));
    chk("initacc_grid",     512'(grid_o), 512'(start_m));

    // Async reset in WRITE: board snaps back without a clock edge
    vecs[0] = '{6'd11, 6'd27, 1'b1, E, WP};
    do_move(0);
    wait_ready("arst");
    move_valid_i = 1'b1; move_from_i = 6'd12; move_to_i = 6'd28;
    @(posedge clk);           // edge N
    #1;
    move_valid_i = 1'b0;
    @(posedge clk);           // edge N+1 -> WRITE
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_sq27",  512'(grid_o[3][3]), 512'(E));
    chk("arst_sq11",  512'(grid_o[1][3]), 512'(WP));
    chk("arst_grid",  512'(grid_o), 512'(start_m));
    chk("arst_ready", 512'(move_ready_o), 512'(0));
    @(negedge clk);
    nrst = 1'b1;
    nd = 0; ne = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      nd += int'(move_done_o); ne += int'(move_err_o);
    end
    chk("arst_no_pulse", 512'(nd + ne), 512'(0));
    chk("arst_ready_after", 512'(move_ready_o), 512'(1));
    chk("arst_grid_after",  512'(grid_o), 512'(start_m));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/board_writer.md
BOARD_WRITER -- requirements
Module: board_writer

Interface
REQ-001 SHALL have parameter INIT_ON_RESET, default 1: 1 means reset loads the standard start position; 0 means reset loads all squares EMPTY.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port nrst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port move_valid_i, input, 1 bit: a move request is present.
REQ-005 SHALL have port move_ready_o, output, 1 bit: the block can accept a move.
REQ-006 SHALL have port move_from_i, input, 6 bits: source square index, row*8+col.
REQ-007 SHALL have port move_to_i, input, 6 bits: destination square index.
REQ-008 SHALL have port init_i, input, 1 bit: synchronous reload of the reset board.
REQ-009 SHALL have port grid_o, output, [7:0][7:0][7:0]: registered board, indexed grid_o[row][col].
REQ-010 SHALL have port move_done_o, output, 1 bit: one-cycle pulse when a move is committed.
REQ-011 SHALL have port move_err_o, output, 1 bit: one-cycle pulse when a move is rejected.

Function
REQ-012 SHALL encode squares as {color[7:6], piece[5:0]}:
- WHITE=01, BLACK=10.
- Piece one-hot: KING=000001, QUEEN=000010, ROOK=000100, KNIGHT=001000, BISHOP=010000, PAWN=100000.
- EMPTY=8'b01_111111.
REQ-013 SHALL hold the start position as follows:
- Index 0..7 = white R,N,B,Q,K,B,N,R; 8..15 = white pawns.
- 16..47 = EMPTY.
- 48..55 = black pawns; 56..63 = black R,N,B,Q,K,B,N,R.
REQ-014 SHALL implement FSM states IDLE, CHECK, WRITE, DONE.
REQ-015 SHALL assert move_ready_o only in IDLE, and SHALL accept a move on a clock edge where move_valid_i and move_ready_o are both high.
REQ-016 SHALL latch from/to on the accepting edge (edge N), go IDLE->CHECK, and ignore later input changes.
REQ-017 SHALL, in CHECK, flag a move illegal when any of these holds:
- from==to.
- The source square is EMPTY.
- The destination color equals the source color.
REQ-018 SHALL, at edge N+2 on a legal move, write the source byte to the destination square and EMPTY to the source square in the same edge.
REQ-019 SHALL leave grid_o unchanged on an illegal move.
REQ-020 SHALL be in DONE for exactly the cycle after edge N+2, with exactly one of move_done_o or move_err_o high, then return to IDLE; move_ready_o SHALL be high again after edge N+3.
REQ-021 SHALL treat capture as overwrite, with no separate capture output.
REQ-022 SHALL give init_i priority in every state:
- The reload takes effect at the next edge and the FSM goes to IDLE.
- Any in-flight move is dropped with no done/err pulse.
- An init_i coinciding with an accepting edge cancels that move.
REQ-023 SHALL drive grid_o directly from registers, with no combinational path from inputs.

Reset
REQ-024 SHALL, on nrst low, load grid_o per INIT_ON_RESET, set the FSM to IDLE, and drive move_done_o=0 and move_err_o=0.
REQ-025 SHALL hold move_ready_o at 0 while nrst is low, and SHALL assert move_ready_o=1 in the first cycle after release.
REQ-026 SHALL abort any in-flight move when reset is asserted mid-operation, with no pulse after release.

Configuration
REQ-027 SHALL compile in auto-promotion when PROMOTION_EN is defined: a PAWN written to row 7 (white) or row 0 (black) SHALL be stored as QUEEN of the same color in the same WRITE edge.
REQ-028 SHALL, when PROMOTION_EN is undefined, write the pawn byte unchanged and omit all promotion logic.

Structure
REQ-029 SHALL take the following from shared package chess_pkg:
- Piece and color constants, and EMPTY.
- square_t (8-bit) and sq_idx_t (6-bit).
- START_BOARD constant [63:0][7:0].
REQ-030 SHALL place the legality tests of REQ-017 in one combinational sub-module, move_check.

Verification
REQ-031 SHALL cover reset then idle: after release, grid_o[0][4]=8'b01_000001, grid_o[7][3]=8'b10_000010, grid_o[3][3]=EMPTY, and move_ready_o=1.
REQ-032 SHALL cover a legal move: from=12, to=28 accepted at edge N; grid_o[3][4]=8'b01_100000 and grid_o[1][4]=EMPTY after edge N+2; move_done_o high for one cycle; move_ready_o low during N+1..N+3.
REQ-033 SHALL cover an illegal move: from=0, to=8 (own pawn); move_err_o pulses once and grid_o is unchanged. from=20 (empty) gives the same result.
REQ-034 SHALL cover a capture: white pawn at 51 moved via a setup sequence, then from=51, to=59; grid_o[7][3]=8'b01_100000 without PROMOTION_EN, 8'b01_000010 with it.
REQ-035 SHALL cover init abort: init_i pulsed in CHECK after a legal move request; no done/err pulse, grid_o equals START_BOARD, move_ready_o=1 next cycle.
REQ-036 SHALL cover async reset mid-WRITE: nrst low between clock edges resets grid_o immediately, and no pulse follows release.
